// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU result monitor: FSM states, err_code bit
// positions and operand width.
package alu_mon_pkg;

   localparam int unsigned OPND_W = 6;

   localparam int unsigned ERR_PAR    = 0;
   localparam int unsigned ERR_ONEHOT = 1;
   localparam int unsigned ERR_VAL    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } mon_state_t;

endpackage

// File: rtl/alu_flag_check.sv
// Combinational consistency checks on one registered ALU result beat.
module alu_flag_check
   import alu_mon_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  logic [7:0]        y,
   input  logic              greater,
   input  logic              less,
   input  logic              is_eq,
   input  logic              parity,
   output logic [2:0]        err_code
);

   always_comb begin
      err_code             = '0;
      err_code[ERR_PAR]    = (parity != (^y));
      err_code[ERR_ONEHOT] = !$onehot({greater, less, is_eq});
      err_code[ERR_VAL]    = (greater != (a > b)) ||
                             (less    != (a < b)) ||
                             (is_eq   != (a == b));
   end

endmodule

// File: rtl/alu_result_monitor.sv
// Two-stage ALU result monitor: stage 1 captures accepted beats, stage 2
// checks them and maintains counters, sticky flags and first-error capture.
module alu_result_monitor
   import alu_mon_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter bit          HALT_ON_ERR = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  logic [1:0]        op,
   input  logic [7:0]        y,
   input  logic              greater,
   input  logic              less,
   input  logic              is_eq,
   input  logic              parity,
   input  logic              overflow,
   input  logic              clr,
   output logic              err_valid,
   output logic [2:0]        err_code,
   output logic [2:0]        err_sticky,
   output logic [CNT_W-1:0]  txn_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [16:0]       first_err,
   output logic              halted
);

   mon_state_t state_q, state_d;
   logic       ready_q;
   logic       accept;

   logic              s1_valid;
   logic [OPND_W-1:0] s1_a, s1_b;
   logic [1:0]        s1_op;
   logic [7:0]        s1_y;
   logic              s1_greater, s1_less, s1_is_eq, s1_parity, s1_overflow;
   logic [2:0]        chk_code;
   logic              chk_fail;
   logic              unused_ovf;

   // ready_q keeps in_ready low throughout reset and until rst_n is sampled high
   assign in_ready   = ready_q && (state_q != HALT);
   assign accept     = in_valid && in_ready && !clr;
   assign halted     = (state_q == HALT);
   assign unused_ovf = s1_overflow;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (HALT_ON_ERR && err_valid) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a        <= a;
         s1_b        <= b;
         s1_op       <= op;
         s1_y        <= y;
         s1_greater  <= greater;
         s1_less     <= less;
         s1_is_eq    <= is_eq;
         s1_parity   <= parity;
         s1_overflow <= overflow;
      end
   end

   alu_flag_check u_check (
      .a        (s1_a),
      .b        (s1_b),
      .y        (s1_y),
      .greater  (s1_greater),
      .less     (s1_less),
      .is_eq    (s1_is_eq),
      .parity   (s1_parity),
      .err_code (chk_code)
   );

   assign chk_fail = s1_valid && (chk_code != '0);

   // err_cnt, err_sticky and first_err update on the same edge that raises err_valid
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         err_valid  <= 1'b0;
         err_code   <= '0;
         err_sticky <= '0;
         txn_cnt    <= '0;
         err_cnt    <= '0;
         first_err  <= '0;
      end else begin
         err_valid <= chk_fail;
         err_code  <= chk_fail ? chk_code : 3'b000;
         if (accept && (txn_cnt != '1)) txn_cnt <= txn_cnt + CNT_W'(1);
         if (chk_fail) begin
            err_sticky <= err_sticky | chk_code;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (err_sticky == '0) first_err <= {s1_op, s1_b, s1_a, chk_code};
         end
      end
   end

endmodule
